// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path and a DMA/loader requester. It provides per-cycle arbitration, locked
// DMA bursts capped at BURST_MAX grants, and a starvation limit after which
// DMA beats the CPU. Read data returns to its owner through a tag pipeline
// that matches the memory read latency.
//
// Optional build macro ARB_STATS_EN adds stat_clr, stat_conflicts and
// stat_dma_grants (saturating conflict and DMA-grant counters).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB      | normal arbitration, CPU first unless DMA is starved
// DMA_LOCK | exclusive DMA burst, CPU is held off
// COOLDOWN | one cycle after a burst, CPU has absolute priority
module dmem_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int MEM_LAT    = 1,
   parameter int BURST_MAX  = 16,
   parameter int STARVE_LIM = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [31:0]       dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_dma_grants
`endif
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM);
   localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      DMA_LOCK = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [SW-1:0]     r_starve_cnt;
   logic [SW-1:0]     w_next_starve;
   logic [BW-1:0]     r_burst_cnt;
   logic [BW-1:0]     w_next_burst;
   logic              w_cpu_gnt;
   logic              w_dma_gnt;
   logic [ADDR_W-1:0] w_cpu_waddr;
   logic [ADDR_W-1:0] r_addr_q;
   logic [31:0]       r_wdata_q;
   logic [MEM_LAT-1:0] r_tag_cpu;
   logic [MEM_LAT-1:0] r_tag_dma;
   logic              w_unused_addr;

   // CPU supplies a byte address; the memory is word addressed.
   assign w_cpu_waddr   = cpu_addr[ADDR_W+1:2];
   assign w_unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

   // Arbitration: grants, next state, burst and starvation counters.
   always_comb begin
      w_next_state  = r_state;
      w_next_burst  = r_burst_cnt;
      w_next_starve = r_starve_cnt;
      w_cpu_gnt     = 1'b0;
      w_dma_gnt     = 1'b0;
      case (r_state)
         ARB: begin
            if (dma_req && (!cpu_req || r_starve_cnt == STARVE_TOP)) begin
               w_dma_gnt = 1'b1;
            end else if (cpu_req) begin
               w_cpu_gnt = 1'b1;
            end
            // A lock request only counts once DMA actually owns the memory.
            if (w_dma_gnt && dma_lock) begin
               w_next_burst = BW'(1);
               w_next_state = (BURST_MAX <= 1) ? COOLDOWN : DMA_LOCK;
            end
         end
         DMA_LOCK: begin
            w_dma_gnt = dma_req;
            if (w_dma_gnt) begin
               w_next_burst = r_burst_cnt + 1'b1;
            end
            if (!dma_lock || (w_dma_gnt && w_next_burst == BURST_TOP)) begin
               w_next_state = COOLDOWN;
            end
         end
         COOLDOWN: begin
            w_cpu_gnt    = cpu_req;
            w_dma_gnt    = dma_req && !cpu_req;
            w_next_burst = '0;
            w_next_state = ARB;
         end
         default: begin
            w_next_state = ARB;
            w_next_burst = '0;
         end
      endcase

      if (r_state == COOLDOWN || !dma_req || w_dma_gnt) begin
         w_next_starve = '0;
      end else if (r_starve_cnt != STARVE_TOP) begin
         w_next_starve = r_starve_cnt + 1'b1;
      end

      // Nothing is granted while reset is held, even from a stale state.
      if (reset) begin
         w_cpu_gnt = 1'b0;
         w_dma_gnt = 1'b0;
      end
   end

   // State register and arbitration counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ARB;
         r_starve_cnt <= '0;
         r_burst_cnt  <= '0;
      end else begin
         r_state      <= w_next_state;
         r_starve_cnt <= w_next_starve;
         r_burst_cnt  <= w_next_burst;
      end
   end

   // Remember the last granted address/data so the memory bus holds when idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr_q  <= '0;
         r_wdata_q <= '0;
      end else if (w_cpu_gnt) begin
         r_addr_q  <= w_cpu_waddr;
         r_wdata_q <= cpu_wdata;
      end else if (w_dma_gnt) begin
         r_addr_q  <= dma_addr;
         r_wdata_q <= dma_wdata;
      end
   end

   // Owner tags of granted reads, shifted to line up with memory latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tag_cpu <= '0;
         r_tag_dma <= '0;
      end else begin
         r_tag_cpu[0] <= w_cpu_gnt && !cpu_we;
         r_tag_dma[0] <= w_dma_gnt && !dma_we;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_tag_cpu[i] <= r_tag_cpu[i-1];
            r_tag_dma[i] <= r_tag_dma[i-1];
         end
      end
   end

   // Memory-side mux and requester-side outputs, all forced low during reset.
   always_comb begin
      cpu_gnt    = w_cpu_gnt;
      dma_gnt    = w_dma_gnt;
      cpu_stall  = cpu_req && !w_cpu_gnt && !reset;
      mem_we     = (w_cpu_gnt && cpu_we) || (w_dma_gnt && dma_we);
      mem_addr   = r_addr_q;
      mem_wdata  = r_wdata_q;
      if (w_cpu_gnt) begin
         mem_addr  = w_cpu_waddr;
         mem_wdata = cpu_wdata;
      end else if (w_dma_gnt) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
      cpu_rvalid = r_tag_cpu[MEM_LAT-1];
      dma_rvalid = r_tag_dma[MEM_LAT-1];
      cpu_rdata  = mem_rdata;
      dma_rdata  = mem_rdata;
      busy       = (r_state != ARB) || (|r_tag_cpu) || (|r_tag_dma);
      if (reset) begin
         mem_addr   = '0;
         mem_wdata  = '0;
         cpu_rvalid = 1'b0;
         dma_rvalid = 1'b0;
         cpu_rdata  = '0;
         dma_rdata  = '0;
         busy       = 1'b0;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] r_stat_conf;
   logic [15:0] r_stat_dgnt;

   // Saturating usage counters; a clear beats a same-cycle increment.
   always_ff @(posedge clock) begin
      if (reset || stat_clr) begin
         r_stat_conf <= '0;
         r_stat_dgnt <= '0;
      end else begin
         if (cpu_req && dma_req && r_stat_conf != 16'hFFFF) begin
            r_stat_conf <= r_stat_conf + 16'd1;
         end
         if (w_dma_gnt && r_stat_dgnt != 16'hFFFF) begin
            r_stat_dgnt <= r_stat_dgnt + 16'd1;
         end
      end
   end

   assign stat_conflicts  = reset ? 16'd0 : r_stat_conf;
   assign stat_dma_grants = reset ? 16'd0 : r_stat_dgnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a BRAM model behind the arbiter, a read scoreboard
// filled as stimulus is issued, and directed grant patterns per scenario.
module tb_dmem_arbiter;

   localparam int ADDR_W     = 14;
   localparam int MEM_LAT    = 2;
   localparam int BURST_MAX  = 16;
   localparam int STARVE_LIM = 8;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we;
   logic [31:0]       cpu_addr, cpu_wdata;
   logic              cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0]       cpu_rdata;
   logic              dma_req, dma_we, dma_lock;
   logic [ADDR_W-1:0] dma_addr;
   logic [31:0]       dma_wdata;
   logic              dma_gnt, dma_rvalid;
   logic [31:0]       dma_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic [31:0]       mem_rdata;
   logic              busy;
`ifdef ARB_STATS_EN
   logic              stat_clr;
   logic [15:0]       stat_conflicts, stat_dma_grants;
`endif

   always #5 clock = ~clock;

   dmem_arbiter #(
      .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .BURST_MAX(BURST_MAX), .STARVE_LIM(STARVE_LIM)
   ) u_dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy)
`ifdef ARB_STATS_EN
      , .stat_clr(stat_clr), .stat_conflicts(stat_conflicts), .stat_dma_grants(stat_dma_grants)
`endif
   );

   function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
      return 32'hC0DE_0000 ^ {a, 18'h0} ^ {18'h0, a};
   endfunction

   // Synchronous BRAM model with MEM_LAT read stages.
   logic [31:0] ram_d [0:DEPTH-1];
   bit          ram_v [0:DEPTH-1];
   logic [31:0] rd_p  [0:MEM_LAT-1];
   always @(posedge clock) begin
      if (mem_we) begin
         ram_d[mem_addr] <= mem_wdata;
         ram_v[mem_addr] <= 1'b1;
      end
      rd_p[0] <= ram_v[mem_addr] ? ram_d[mem_addr] : init_val(mem_addr);
      for (int i = 1; i < MEM_LAT; i++) rd_p[i] <= rd_p[i-1];
   end
   assign mem_rdata = rd_p[MEM_LAT-1];

   typedef struct packed {
      logic        own_dma;
      logic [31:0] data;
      logic [31:0] stamp;
   } sb_t;

   sb_t         sb_q [$];
   sb_t         mon_e;
   logic [31:0] sh_d [0:DEPTH-1];
   bit          sh_v [0:DEPTH-1];
   logic [31:0] cyc_n = '0;
   int          total = 0;
   int          bad   = 0;

   always @(posedge clock) cyc_n <= cyc_n + 32'd1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected outcome of an access the bench expects to be granted.
   task automatic sb_note(input logic own, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d);
      sb_t e;
      if (we) begin
         sh_v[a] = 1'b1;
         sh_d[a] = d;
      end else begin
         e.own_dma = own;
         e.data    = sh_v[a] ? sh_d[a] : init_val(a);
         e.stamp   = cyc_n;
         sb_q.push_back(e);
      end
   endtask

   // Read-return monitor: pops the scoreboard on every rvalid.
   always @(negedge clock) begin
      if (!reset) begin
         if (cpu_rvalid || dma_rvalid) begin
            chk("rv_both", 32'(cpu_rvalid & dma_rvalid), 32'd0);
            if (sb_q.size() == 0) begin
               chk("rv_unexp", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rv_owner", 32'(dma_rvalid), 32'(mon_e.own_dma));
               chk("rv_data", dma_rvalid ? dma_rdata : cpu_rdata, mon_e.data);
               chk("rv_lat", cyc_n - mon_e.stamp, 32'(MEM_LAT));
            end
         end
         if (sb_q.size() != 0 && (cyc_n - sb_q[0].stamp) > 32'(MEM_LAT)) begin
            mon_e = sb_q.pop_front();
            chk("rv_miss", cyc_n - mon_e.stamp, 32'(MEM_LAT));
         end
      end
   end

   // One clock of stimulus with the grant the bench expects.
   task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic dl,
                      input logic [ADDR_W-1:0] da, input logic [31:0] dd,
                      input logic ecg, input logic edg, input string tag);
      logic [ADDR_W-1:0] cwa;
      cwa = ca[ADDR_W+1:2];
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
      if (!reset) begin
         if (ecg) sb_note(1'b0, cw, cwa, cd);
         if (edg) sb_note(1'b1, dw, da, dd);
      end
      #2;
      chk({tag, "_cgnt"}, 32'(cpu_gnt), 32'(ecg));
      chk({tag, "_dgnt"}, 32'(dma_gnt), 32'(edg));
      chk({tag, "_stall"}, 32'(cpu_stall), 32'(!reset && cr && !ecg));
      if (ecg || edg) begin
         chk({tag, "_maddr"}, 32'(mem_addr), 32'(ecg ? cwa : da));
         chk({tag, "_mwe"}, 32'(mem_we), 32'(ecg ? cw : dw));
         if (ecg ? cw : dw) chk({tag, "_mwd"}, mem_wdata, ecg ? cd : dd);
      end
      if (reset) begin
         chk({tag, "_rst_addr"}, 32'(mem_addr), 32'd0);
         chk({tag, "_rst_wd"}, mem_wdata, 32'd0);
         chk({tag, "_rst_ctl"}, {27'd0, mem_we, busy, cpu_stall, cpu_rvalid, dma_rvalid}, 32'd0);
         chk({tag, "_rst_rd"}, cpu_rdata | dma_rdata, 32'd0);
      end
      @(posedge clock);
      #1;
   endtask

   // Idle clock; exp_busy < 0 skips the busy check.
   task automatic idle(input int exp_busy, input string tag);
      cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
      #2;
      if (exp_busy >= 0) chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, "_idle"}, {30'd0, cpu_gnt, dma_gnt}, 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int ci, di;
      logic dgx;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(posedge clock);
      #1;
      cyc(1, 0, 32'h10, 0, 1, 0, 1, 14'h5, 0, 0, 0, "rst");
      reset = 1'b0;

      // CPU alone reads byte 0x10 (word 4), then write, bus hold, read-back.
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 14'h0, 0, 1, 0, "t1");
      idle(1, "t1a"); idle(1, "t1b"); idle(0, "t1c");
      cyc(1, 1, 32'h40, 32'h1111_2222, 0, 0, 0, 14'h0, 0, 1, 0, "t1w");
      cpu_req = 1'b0; cpu_we = 1'b0;
      #2;
      chk("hold_addr", 32'(mem_addr), 32'h10);
      chk("hold_wd", mem_wdata, 32'h1111_2222);
      chk("hold_we", 32'(mem_we), 32'd0);
      @(posedge clock);
      #1;
      cyc(0, 0, 32'h0, 0, 1, 0, 0, 14'h10, 0, 0, 1, "t1rd");
      idle(1, "t1d"); idle(1, "t1e"); idle(0, "t1f");

      // Continuous contention: DMA wins once every STARVE_LIM+1 cycles.
      ci = 0; di = 0;
      for (int k = 0; k < 27; k++) begin
         dgx = (k % (STARVE_LIM + 1)) == STARVE_LIM;
         cyc(1, 0, 32'h100 + 32'(4 * ci), 0, 1, 1, 0, ADDR_W'(32'h200 + 32'(di)),
             32'hBEEF_0000 + 32'(di), !dgx, dgx, "t2");
         if (dgx) di++; else ci++;
      end
      idle(-1, "t2a"); idle(-1, "t2b"); idle(-1, "t2c");
      for (int j = 0; j < 3; j++)
         cyc(1, 0, 32'h800 + 32'(4 * j), 0, 0, 0, 0, 14'h0, 0, 1, 0, "t2rb");
      idle(-1, "t2d"); idle(-1, "t2e");

      // A DMA request that drops clears the starvation count.
      ci = 0;
      for (int k = 0; k < 13; k++) begin
         dgx = (k == 12);
         cyc(1, 1, 32'h5000 + 32'(4 * ci), 32'(k), (k != 3), 0, 0, 14'h700, 0,
             !dgx, dgx, "t2b");
         if (!dgx) ci++;
      end
      idle(-1, "t2f"); idle(-1, "t2g"); idle(0, "t2h");

      // Locked burst under CPU contention: truncated at BURST_MAX grants.
      ci = 0; di = 0;
      for (int k = 0; k < 34; k++) begin
         dgx = (k >= STARVE_LIM && k < STARVE_LIM + BURST_MAX) || (k == 33);
         cyc(1, 1, 32'h1000 + 32'(4 * ci), 32'hA000_0000 + 32'(k), 1, 0, 1,
             ADDR_W'(32'h300 + 32'(di)), 0, !dgx, dgx, "t3");
         if (dgx) di++; else ci++;
      end
      idle(1, "t3a"); idle(1, "t3b"); idle(0, "t3c");

      // Lock dropped early; cooldown grants DMA without re-locking.
      cyc(0, 0, 32'h0, 0, 1, 0, 1, 14'h400, 0, 0, 1, "t4a");
      cyc(0, 0, 32'h0, 0, 1, 0, 1, 14'h401, 0, 0, 1, "t4b");
      cyc(0, 0, 32'h0, 0, 1, 0, 1, 14'h402, 0, 0, 1, "t4c");
      idle(1, "t4lock");
      cyc(0, 0, 32'h0, 0, 1, 0, 1, 14'h403, 0, 0, 1, "t4cool");
      cyc(1, 0, 32'h2000, 0, 1, 0, 0, 14'h404, 0, 1, 0, "t4arb");
      cyc(0, 0, 32'h2000, 0, 1, 0, 0, 14'h404, 0, 0, 1, "t4d");
      idle(1, "t4e"); idle(1, "t4f"); idle(0, "t4g");

      // Reset one cycle after a locked DMA read: no return, back in ARB.
      cyc(0, 0, 32'h0, 0, 1, 0, 1, 14'h500, 0, 0, 1, "t5a");
      reset = 1'b1;
      sb_q.delete();
      cyc(1, 0, 32'h3000, 0, 1, 0, 1, 14'h501, 0, 0, 0, "t5rst");
      reset = 1'b0;
      cyc(1, 0, 32'h3000, 0, 1, 0, 1, 14'h501, 0, 1, 0, "t5arb");
      idle(1, "t5b"); idle(1, "t5c"); idle(0, "t5d");

`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      idle(-1, "stc");
      stat_clr = 1'b0;
      cyc(0, 0, 32'h0, 0, 1, 1, 0, 14'h600, 32'd1, 0, 1, "std1");
      cyc(0, 0, 32'h0, 0, 1, 1, 0, 14'h601, 32'd2, 0, 1, "std2");
      for (int k = 0; k < 5; k++)
         cyc(1, 1, 32'h4000 + 32'(4 * k), 32'(k), 1, 0, 0, 14'h602, 0, 1, 0, "stk");
      chk("st_conf5", 32'(stat_conflicts), 32'd5);
      chk("st_dgnt2", 32'(stat_dma_grants), 32'd2);
      stat_clr = 1'b1;
      cyc(1, 1, 32'h4100, 0, 1, 0, 0, 14'h602, 0, 1, 0, "stclr");
      stat_clr = 1'b0;
      chk("st_conf0", 32'(stat_conflicts), 32'd0);
      chk("st_dgnt0", 32'(stat_dma_grants), 32'd0);
      idle(-1, "ste");
`endif

      idle(-1, "end1"); idle(-1, "end2"); idle(0, "end3");
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
